// File: rtl/hub75_pkg.sv
// Shared types and colour-word helpers for the HUB75 BCM panel driver.
package hub75_pkg;

  typedef enum logic [1:0] {
    BLANK   = 2'd0,
    SHIFT   = 2'd1,
    LATCH   = 2'd2,
    DISPLAY = 2'd3
  } state_t;

  // Widest colour word the helpers accept; narrower words are zero-extended.
  localparam int unsigned MAX_CWD = 48;

  // Bit `sh` of a zero-extended colour word.
  function automatic logic word_bit(input logic [MAX_CWD-1:0] w, input int unsigned sh);
    logic [MAX_CWD-1:0] s;
    s = w >> sh;
    return s[0];
  endfunction

  // Word layout is {R,G,B}, each channel `bits` wide, MSB first.
  function automatic logic r_bit(input logic [MAX_CWD-1:0] w, input int unsigned bits,
                                 input int unsigned plane);
    return word_bit(w, 2 * bits + plane);
  endfunction

  function automatic logic g_bit(input logic [MAX_CWD-1:0] w, input int unsigned bits,
                                 input int unsigned plane);
    return word_bit(w, bits + plane);
  endfunction

  function automatic logic b_bit(input logic [MAX_CWD-1:0] w, input int unsigned bits,
                                 input int unsigned plane);
    return word_bit(w, plane + 0 * bits);
  endfunction

endpackage

// File: rtl/hub75_tick_gen.sv
// Single-cycle tick every CLK_DIV clk_in cycles; first tick CLK_DIV cycles after reset.
module hub75_tick_gen #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk_in,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Modulo counter; tick is registered one count early so it lands on the wrap.
  always_comb begin
    cnt_d  = (cnt_q == DW'(CLK_DIV - 1)) ? '0 : cnt_q + DW'(1);
    tick_d = (cnt_q == DW'(CLK_DIV - 2));
  end

  // Counter and tick registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 scan driver with binary-code modulation and frame-boundary bank swap.
module hub75_bcm_driver
  import hub75_pkg::*;
#(
  parameter  int unsigned COLS        = 64,
  parameter  int unsigned ROWS        = 64,
  parameter  int unsigned BITS        = 3,
  parameter  int unsigned CLK_DIV     = 8,
  parameter  int unsigned BASE_TIME   = 32,
  parameter  int unsigned BLANK_TICKS = 2,
  localparam int unsigned SR          = ROWS / 2,
  localparam int unsigned RW          = (SR > 1) ? $clog2(SR) : 1,
  localparam int unsigned CW          = $clog2(COLS),
  localparam int unsigned CWD         = 3 * BITS
) (
  input  logic           clk_in,
  input  logic           reset,
  output logic           rd_bank,
  output logic [RW-1:0]  rd_row,
  output logic [CW-1:0]  rd_col,
  input  logic [CWD-1:0] rd_top,
  input  logic [CWD-1:0] rd_bot,
  input  logic           swap_req,
  output logic           swap_ack,
  output logic           frame_start,
  output logic [RW-1:0]  row_addr,
  output logic           R1,
  output logic           G1,
  output logic           B1,
  output logic           R2,
  output logic           G2,
  output logic           B2,
  output logic           CLK,
  output logic           LAT,
  output logic           OE
);

  localparam int unsigned PW  = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned TWD = $clog2(BASE_TIME << (BITS - 1)) + 1;
  localparam int unsigned TWB = $clog2(BLANK_TICKS) + 1;
  localparam int unsigned TW  = (TWD > TWB) ? TWD : TWB;

  logic tick;

  hub75_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .tick   (tick)
  );

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d, row_addr_q, row_addr_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [CW-1:0] col_q, col_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          bank_q, bank_d, pend_q, pend_d, ack_q, ack_d, fs_q, fs_d;
  logic          sclk_q, sclk_d, lat_q, lat_d, oe_q, oe_d;
  logic [5:0]    pix_q, pix_d;
  logic [RW-1:0] row_nxt_c;

  // Panel data bits {R1,G1,B1,R2,G2,B2} for one bit plane of both half-panel words.
  function automatic logic [5:0] pix_of(input logic [CWD-1:0] top_w, input logic [CWD-1:0] bot_w,
                                        input int unsigned p);
    return {r_bit(MAX_CWD'(top_w), BITS, p), g_bit(MAX_CWD'(top_w), BITS, p),
            b_bit(MAX_CWD'(top_w), BITS, p), r_bit(MAX_CWD'(bot_w), BITS, p),
            g_bit(MAX_CWD'(bot_w), BITS, p), b_bit(MAX_CWD'(bot_w), BITS, p)};
  endfunction

  assign row_nxt_c = (row_q == RW'(SR - 1)) ? '0 : row_q + RW'(1);

  // Next-state and registered-output decode; outputs describe the tick period being entered.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    row_addr_d = row_addr_q;
    plane_d    = plane_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    bank_d     = bank_q;
    pend_d     = pend_q | swap_req;
    ack_d      = 1'b0;
    fs_d       = 1'b0;
    sclk_d     = sclk_q;
    lat_d      = lat_q;
    oe_d       = oe_q;
    pix_d      = pix_q;
    if (tick) begin
      case (state_q)
        BLANK: begin
          if (cnt_q == TW'(BLANK_TICKS - 1)) begin
            state_d = SHIFT;
            cnt_d   = '0;
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            pix_d   = pix_of(rd_top, rd_bot, 32'(plane_q));
            fs_d    = (row_q == '0);
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        SHIFT: begin
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
            col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
          end else if (col_q == '0) begin
            // Column counter has wrapped: every column of this plane is shifted.
            state_d = LATCH;
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            lat_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            pix_d   = pix_of(rd_top, rd_bot, 32'(plane_q));
          end
        end
        LATCH: begin
          state_d = DISPLAY;
          lat_d   = 1'b0;
          oe_d    = 1'b0;
          cnt_d   = '0;
        end
        DISPLAY: begin
          if (cnt_q == TW'((BASE_TIME << plane_q) - 1)) begin
            oe_d  = 1'b1;
            cnt_d = '0;
            if (plane_q != PW'(BITS - 1)) begin
              state_d = SHIFT;
              plane_d = plane_q + PW'(1);
              phase_d = 1'b0;
              sclk_d  = 1'b0;
              pix_d   = pix_of(rd_top, rd_bot, 32'(plane_q) + 32'd1);
            end else begin
              state_d    = BLANK;
              plane_d    = '0;
              row_d      = row_nxt_c;
              row_addr_d = row_nxt_c;
              if (row_q == RW'(SR - 1) && (pend_q || swap_req)) begin
                bank_d = ~bank_q;
                ack_d  = 1'b1;
                pend_d = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  // State, counter and panel output registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= BLANK;
      row_q      <= '0;
      row_addr_q <= '0;
      plane_q    <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      bank_q     <= 1'b0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      fs_q       <= 1'b0;
      sclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      oe_q       <= 1'b1;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      row_addr_q <= row_addr_d;
      plane_q    <= plane_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bank_q     <= bank_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      fs_q       <= fs_d;
      sclk_q     <= sclk_d;
      lat_q      <= lat_d;
      oe_q       <= oe_d;
      pix_q      <= pix_d;
    end
  end

  assign rd_bank     = bank_q;
  assign rd_row      = row_q;
  assign rd_col      = col_q;
  assign swap_ack    = ack_q;
  assign frame_start = fs_q;
  assign row_addr    = row_addr_q;
  assign {R1, G1, B1, R2, G2, B2} = pix_q;
  assign CLK         = sclk_q;
  assign LAT         = lat_q;
  assign OE          = oe_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Bench for hub75_bcm_driver: 64-column panel with 2 scan rows to keep frames short.
module tb_hub75_bcm_driver;

  localparam int COLS        = 64;
  localparam int ROWS        = 4;
  localparam int SR          = ROWS / 2;
  localparam int BITS        = 3;
  localparam int CLK_DIV     = 8;
  localparam int BASE_TIME   = 32;
  localparam int BLANK_TICKS = 2;
  localparam int ROW_CYC     = CLK_DIV * (BITS * (2 * COLS + 1) + BASE_TIME * ((1 << BITS) - 1) + BLANK_TICKS);
  localparam int FRAME_CYC   = SR * ROW_CYC;
  localparam int FS_OFF      = CLK_DIV * BLANK_TICKS;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       rd_bank, swap_ack, frame_start, swap_req;
  logic [0:0] rd_row, row_addr;
  logic [5:0] rd_col;
  logic [8:0] rd_top, rd_bot;
  logic       R1, G1, B1, R2, G2, B2, CLK, LAT, OE;
  logic [5:0] pix;

  hub75_bcm_driver #(
    .COLS(COLS), .ROWS(ROWS), .BITS(BITS), .CLK_DIV(CLK_DIV),
    .BASE_TIME(BASE_TIME), .BLANK_TICKS(BLANK_TICKS)
  ) dut (
    .clk_in(clk_in), .reset(reset), .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col),
    .rd_top(rd_top), .rd_bot(rd_bot), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_start(frame_start), .row_addr(row_addr),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
    .CLK(CLK), .LAT(LAT), .OE(OE)
  );

  assign pix = {R1, G1, B1, R2, G2, B2};

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame-memory contents (bank independent); row 0 column 5 carries the reference pattern.
  function automatic logic [8:0] mem_top(input int row, input int col);
    if (row == 0 && col == 5) return 9'b101_010_111;
    return 9'((col * 37 + row * 11 + 5) % 512);
  endfunction

  function automatic logic [8:0] mem_bot(input int row, input int col);
    if (row == 0 && col == 5) return 9'b000_111_001;
    return 9'((col * 53 + row * 29 + 200) % 512);
  endfunction

  function automatic logic bit_at(input logic [8:0] w, input int sh);
    logic [8:0] s;
    s = w >> sh;
    return s[0];
  endfunction

  function automatic logic [5:0] exp_pix(input int row, input int p, input int col);
    logic [8:0] t, b;
    t = mem_top(row, col);
    b = mem_bot(row, col);
    return {bit_at(t, 6 + p), bit_at(t, 3 + p), bit_at(t, p),
            bit_at(b, 6 + p), bit_at(b, 3 + p), bit_at(b, p)};
  endfunction

  // Memory with one cycle of read latency.
  always @(posedge clk_in) begin
    rd_top <= mem_top(32'(rd_row), 32'(rd_col));
    rd_bot <= mem_bot(32'(rd_row), 32'(rd_col));
  end

  // Cycles since reset release; the first edge after release is cycle 1.
  always @(posedge clk_in or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         row;
    int         plane;
    int         col;
    logic [5:0] pix;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [5:0] col5_exp [3] = '{6'b101_011, 6'b011_010, 6'b101_010};
  int         gen_row, nrise, nrow, frame_n, exp_plane, lat_t, oe_t;
  logic       prev_clk, prev_lat, prev_oe, exp_bank, exp_pend, rowchg, wrap, exp_ack, exp_fs;
  logic [0:0] prev_row;

  // Scoreboard and timing monitor, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (reset) begin
      sb.delete();
      gen_row = 0; nrise = 0; nrow = 0; frame_n = 0; exp_plane = 0; lat_t = 0; oe_t = 0;
      prev_clk = 1'b0; prev_lat = 1'b0; prev_oe = 1'b1; prev_row = 1'b0;
      exp_bank = 1'b0; exp_pend = 1'b0;
    end else begin
      while (sb.size() < COLS * BITS) begin
        for (int p = 0; p < BITS; p++)
          for (int c = 0; c < COLS; c++)
            sb.push_back('{gen_row, p, c, exp_pix(gen_row, p, c)});
        gen_row = (gen_row + 1) % SR;
      end
      if (CLK && !prev_clk) begin
        nrise++;
        e = sb.pop_front();
        chk("oe_in_shift", 32'(OE), 1);
        chk("pix", 32'(pix), 32'(e.pix));
        chk("pix_row", 32'(row_addr), e.row);
        if (e.row == 0 && e.col == 5) chk("col5_plane", 32'(pix), 32'(col5_exp[e.plane]));
      end
      if (LAT && !prev_lat) begin
        lat_t = cyc;
        chk("lat_clk", 32'(CLK), 0);
      end
      if (!LAT && prev_lat) begin
        chk("lat_len", cyc - lat_t, CLK_DIV);
        chk("clk_per_plane", nrise, COLS);
        nrise = 0;
      end
      if (!OE && prev_oe) oe_t = cyc;
      if (OE && !prev_oe) begin
        chk("oe_low", cyc - oe_t, (CLK_DIV * BASE_TIME) << exp_plane);
        exp_plane = (exp_plane + 1) % BITS;
      end
      rowchg  = (row_addr != prev_row);
      wrap    = rowchg && (32'(prev_row) == SR - 1);
      exp_ack = wrap && exp_pend;
      if (exp_ack) begin
        exp_bank = ~exp_bank;
        exp_pend = 1'b0;
      end
      if (rowchg) begin
        chk("row_seq", 32'(row_addr), (32'(prev_row) + 1) % SR);
        chk("row_period", cyc, (nrow + 1) * ROW_CYC);
        chk("row_chg_oe", 32'(OE), 1);
        nrow++;
      end
      if (swap_ack || exp_ack) chk("swap_ack", 32'(swap_ack), 32'(exp_ack));
      if (rowchg || rd_bank !== exp_bank) chk("rd_bank", 32'(rd_bank), 32'(exp_bank));
      exp_fs = (cyc == frame_n * FRAME_CYC + FS_OFF);
      if (frame_start || exp_fs) begin
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        if (frame_start) frame_n++;
      end
      prev_clk = CLK;
      prev_lat = LAT;
      prev_oe  = OE;
      prev_row = row_addr;
    end
  end

  // Wait until cycle n has been reached, then step just past the falling edge.
  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 120000) begin
      @(negedge clk_in);
      guard++;
    end
    if (cyc < n) chk("wait_timeout", cyc, n);
    #1;
  endtask

  task automatic pulse_swap;
    swap_req = 1'b1;
    exp_pend = 1'b1;
    @(negedge clk_in);
    #1;
    swap_req = 1'b0;
  endtask

  int r0;

  initial begin
    swap_req = 1'b0;
    #2 reset = 1'b1;
    repeat (5) @(negedge clk_in);
    #1;
    chk("rst_clk", 32'(CLK), 0);
    chk("rst_lat", 32'(LAT), 0);
    chk("rst_oe", 32'(OE), 1);
    chk("rst_pix", 32'(pix), 0);
    chk("rst_row_addr", 32'(row_addr), 0);
    chk("rst_bank", 32'(rd_bank), 0);
    chk("rst_ack", 32'(swap_ack), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_rd_col", 32'(rd_col), 0);
    reset = 1'b0;

    // Two blank ticks, then shifting of row 0 plane 0.
    wait_cyc(FS_OFF - 1);
    chk("pre_fs", 32'(frame_start), 0);
    wait_cyc(FS_OFF);
    chk("first_fs", 32'(frame_start), 1);
    chk("first_shift_clk", 32'(CLK), 0);
    wait_cyc(FS_OFF + CLK_DIV);
    chk("first_clk_rise", 32'(CLK), 1);

    // Swap requested mid-frame takes effect at the frame end only.
    wait_cyc(999);
    pulse_swap();
    wait_cyc(FRAME_CYC - 1);
    chk("bank_before_end", 32'(rd_bank), 0);
    wait_cyc(FRAME_CYC);
    chk("bank_at_end", 32'(rd_bank), 1);
    chk("ack_at_end", 32'(swap_ack), 1);
    wait_cyc(FRAME_CYC + 1);
    chk("ack_one_cycle", 32'(swap_ack), 0);

    // Two requests in one frame collapse into a single toggle.
    wait_cyc(FRAME_CYC + 2000);
    pulse_swap();
    wait_cyc(FRAME_CYC + 5000);
    pulse_swap();
    wait_cyc(2 * FRAME_CYC + 1);
    chk("bank_double_req", 32'(rd_bank), 0);
    wait_cyc(3 * FRAME_CYC + 1);
    chk("bank_no_req", 32'(rd_bank), 0);

    // Request coincident with the frame-end edge.
    wait_cyc(4 * FRAME_CYC - 1);
    pulse_swap();
    chk("bank_coincident", 32'(rd_bank), 1);

    // Asynchronous reset in the middle of row 1, plane 1, column 20.
    r0 = 4 * FRAME_CYC + ROW_CYC;
    wait_cyc(r0 + 1628);
    chk("pre_rst_col", 32'(rd_col), 20);
    wait_cyc(r0 + 1635);
    chk("pre_rst_clk", 32'(CLK), 1);
    chk("pre_rst_row", 32'(row_addr), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_oe", 32'(OE), 1);
    chk("mid_rst_clk", 32'(CLK), 0);
    chk("mid_rst_row", 32'(row_addr), 0);
    chk("mid_rst_bank", 32'(rd_bank), 0);
    repeat (3) @(negedge clk_in);
    #1;
    reset = 1'b0;
    wait_cyc(FS_OFF);
    chk("restart_fs", 32'(frame_start), 1);
    chk("restart_row", 32'(row_addr), 0);
    wait_cyc(FRAME_CYC + 20);
    chk("restart_bank", 32'(rd_bank), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
